// File: rtl/console_writer_if.sv
// +----------------------------------------------------------------------+
// | console_writer_if: CPU push port plus console stb/ack write bus.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface console_writer_if;
  logic        push;
  logic [7:0]  push_data;
  logic        full;
  logic        empty;
  logic        busy;
  logic        wb_stb;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        wb_stall;
  logic        overflow;
  logic        timeout;

  modport master (
    input  push, push_data, wb_ack, wb_stall,
    output full, empty, busy, wb_stb, wb_data, overflow, timeout
  );

  modport slave (
    output push, push_data, wb_ack, wb_stall,
    input  full, empty, busy, wb_stb, wb_data, overflow, timeout
  );
endinterface

`default_nettype wire

// File: rtl/console_writer.sv
// +----------------------------------------------------------------------+
// | console_writer: FIFO-buffered single-beat console write initiator.  |
// | Optional macro CONSOLE_WRITER_CRLF_EN expands 0x0A into 0x0D,0x0A.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module console_writer #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  console_writer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [0:0]    state;
  logic [TW-1:0] timer;
  logic          stb;
  logic [31:0]   data;
  logic          overflow;
  logic          timeout;

  logic          fifo_full;
  logic          fifo_empty;
  logic          do_push;
  logic          do_pop;
  logic          issue;
  logic          expire;
  logic [7:0]    head;
  logic [7:0]    tx_byte;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign do_push    = bus.push && !fifo_full;

`ifdef CONSOLE_WRITER_CRLF_EN
  logic cr_sent;
  logic insert_cr;

  always_comb begin
    issue     = (state == S_IDLE) && !fifo_empty && !bus.wb_stall;
    expire    = (state == S_WAIT) && !bus.wb_ack && (timer == TIMEOUT_LAST);
    insert_cr = (head == 8'h0A) && !cr_sent;
    tx_byte   = insert_cr ? 8'h0D : head;
    // A lost CR drops its LF too, so the pair never emits half a newline
    do_pop    = (issue && !insert_cr) || (expire && cr_sent);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_sent <= 1'b0;
    end else if (issue) begin
      cr_sent <= insert_cr;
    end else if (expire && cr_sent) begin
      cr_sent <= 1'b0;
    end
  end
`else
  always_comb begin
    issue   = (state == S_IDLE) && !fifo_empty && !bus.wb_stall;
    expire  = (state == S_WAIT) && !bus.wb_ack && (timer == TIMEOUT_LAST);
    tx_byte = head;
    do_pop  = issue;
  end
`endif

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.push && fifo_full) overflow <= 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      stb     <= 1'b0;
      data    <= '0;
      timeout <= 1'b0;
    end else begin
      stb <= 1'b0;
      if (state == S_IDLE) begin
        if (issue) begin
          stb   <= 1'b1;
          data  <= {24'b0, tx_byte};
          timer <= '0;
          state <= S_WAIT;
        end
      end else begin
        // Ack is honoured on the strobe cycle itself as well
        if (bus.wb_ack) begin
          state <= S_IDLE;
        end else if (timer == TIMEOUT_LAST) begin
          timeout <= 1'b1;
          state   <= S_IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.busy     = (state != S_IDLE) || !fifo_empty;
  assign bus.wb_stb   = stb;
  assign bus.wb_data  = data;
  assign bus.overflow = overflow;
  assign bus.timeout  = timeout;
endmodule

`default_nettype wire

// File: tb/tb_console_writer.sv
// +----------------------------------------------------------------------+
// | tb_console_writer: directed self-checking bench for console_writer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_console_writer;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic        ack_en    = 1'b0;
  logic        force_ack = 1'b0;
  logic        ack_pend  = 1'b0;
  logic        prev_stb  = 1'b0;
  int          stb_long  = 0;
  logic [31:0] emitted[$];

  console_writer_if bus ();

  console_writer #(.DEPTH(8), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Console model: records every strobe and acks one cycle after it when enabled
  always @(negedge clk) begin
    if (bus.wb_stb === 1'b1) begin
      emitted.push_back(bus.wb_data);
      if (prev_stb) stb_long++;
    end
    prev_stb   = (bus.wb_stb === 1'b1);
    bus.wb_ack = force_ack | (ack_en & ack_pend);
    ack_pend   = ack_en & (bus.wb_stb === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.push      = 1'b1;
    bus.push_data = b;
    tick();
    bus.push      = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (!bus.busy) break;
      tick();
    end
    chk(tag, {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic wait_stb(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (bus.wb_stb) break;
      tick();
    end
    chk(tag, {31'b0, bus.wb_stb}, 32'd1);
  endtask

  initial begin
    int nb;
    int ns;
    int n;
    rst           = 1'b1;
    bus.push      = 1'b0;
    bus.push_data = 8'h00;
    bus.wb_stall  = 1'b0;
    repeat (3) tick();

    chk("rst_stb",      {31'b0, bus.wb_stb},   32'd0);
    chk("rst_data",     bus.wb_data,           32'd0);
    chk("rst_empty",    {31'b0, bus.empty},    32'd1);
    chk("rst_full",     {31'b0, bus.full},     32'd0);
    chk("rst_overflow", {31'b0, bus.overflow}, 32'd0);
    chk("rst_timeout",  {31'b0, bus.timeout},  32'd0);
    chk("rst_busy",     {31'b0, bus.busy},     32'd0);
    rst = 1'b0;
    tick();

    // Three characters, acked one cycle after each strobe
    ack_en = 1'b1;
    emitted.delete();
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    drain("abc_drain", 60);
    chk("abc_count", emitted.size(), 32'd3);
    chk("abc_0", emitted[0], 32'h0000_0041);
    chk("abc_1", emitted[1], 32'h0000_0042);
    chk("abc_2", emitted[2], 32'h0000_0043);
    chk("abc_empty", {31'b0, bus.empty}, 32'd1);

    // Stall holds off the request; busy stays high throughout
    bus.wb_stall = 1'b1;
    push_byte(8'h11);
    push_byte(8'h22);
    emitted.delete();
    nb = 0;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.busy) nb++;
      if (bus.wb_stb) ns++;
    end
    chk("stall_busy_low", nb, 32'd0);
    chk("stall_stb", ns, 32'd0);
    bus.wb_stall = 1'b0;
    tick();
    chk("unstall_stb", {31'b0, bus.wb_stb}, 32'd1);
    chk("unstall_data", bus.wb_data, 32'h0000_0011);
    drain("stall_drain", 60);
    chk("stall_count", emitted.size(), 32'd2);
    chk("stall_1", emitted[1], 32'h0000_0022);

    // Nine pushes into an eight-deep FIFO while stalled
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_byte(8'h30 + 8'(i));
      if (i == 7) begin
        chk("ovf_full8", {31'b0, bus.full}, 32'd1);
        chk("ovf_not_yet", {31'b0, bus.overflow}, 32'd0);
      end
    end
    chk("ovf_set", {31'b0, bus.overflow}, 32'd1);
    chk("ovf_full9", {31'b0, bus.full}, 32'd1);
    emitted.delete();
    bus.wb_stall = 1'b0;
    drain("ovf_drain", 200);
    chk("ovf_count", emitted.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", emitted[i], 32'h30 + 32'(i));
    end
    chk("ovf_sticky", {31'b0, bus.overflow}, 32'd1);

    // No ack: the first byte times out 64 cycles after its strobe
    ack_en = 1'b0;
    push_byte(8'h55);
    push_byte(8'h66);
    wait_stb("to_stb55", 10);
    chk("to_data55", bus.wb_data, 32'h0000_0055);
    repeat (63) tick();
    chk("to_not_yet", {31'b0, bus.timeout}, 32'd0);
    tick();
    chk("to_set", {31'b0, bus.timeout}, 32'd1);
    chk("to_stb_gap", {31'b0, bus.wb_stb}, 32'd0);
    tick();
    chk("to_stb66", {31'b0, bus.wb_stb}, 32'd1);
    chk("to_data66", bus.wb_data, 32'h0000_0066);
    ack_en = 1'b1;
    drain("to_drain", 20);
    chk("to_sticky", {31'b0, bus.timeout}, 32'd1);

    // Reset while the strobe is up with three bytes still queued
    ack_en = 1'b0;
    bus.wb_stall = 1'b1;
    push_byte(8'h71);
    push_byte(8'h72);
    push_byte(8'h73);
    push_byte(8'h74);
    bus.wb_stall = 1'b0;
    wait_stb("rw_stb", 10);
    chk("rw_data", bus.wb_data, 32'h0000_0071);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_stb_drop", {31'b0, bus.wb_stb},   32'd0);
    chk("rw_empty",    {31'b0, bus.empty},    32'd1);
    chk("rw_timeout",  {31'b0, bus.timeout},  32'd0);
    chk("rw_overflow", {31'b0, bus.overflow}, 32'd0);
    chk("rw_busy",     {31'b0, bus.busy},     32'd0);
    n = emitted.size();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    repeat (5) tick();
    chk("rw_late_ack", emitted.size(), 32'(n));
    chk("rw_idle", {31'b0, bus.busy}, 32'd0);

    // Newline handling
    ack_en = 1'b1;
    emitted.delete();
    push_byte(8'h48);
    push_byte(8'h0A);
    drain("nl_drain", 60);
    chk("nl_0", emitted[0], 32'h0000_0048);
`ifdef CONSOLE_WRITER_CRLF_EN
    chk("nl_count", emitted.size(), 32'd3);
    chk("nl_1", emitted[1], 32'h0000_000D);
    chk("nl_2", emitted[2], 32'h0000_000A);
`else
    chk("nl_count", emitted.size(), 32'd2);
    chk("nl_1", emitted[1], 32'h0000_000A);
`endif

    chk("stb_single_cycle", stb_long, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
